// File: rtl/tcore_param.sv
// Shared core parameters: branch-predictor defaults, FSM states and the
// resolved-branch update record.
package tcore_param;

    localparam int PHT_SIZE_DEF = 256;
    localparam int BTB_SIZE_DEF = 128;
    localparam int GHR_LEN_DEF  = 10;
    localparam int CNT_BITS_DEF = 2;

    // Widest history checkpoint the update record can carry.
    localparam int GHR_MAX = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [GHR_MAX-1:0] ghr;
        logic               taken;
        logic [31:0]        target;
        logic               mispredict;
    } bp_upd_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: asynchronous read port, one write
// port and a clear-by-index port. Storage is not reset; the owner clears it.
module bp_btb #(
    parameter  int SIZE  = 128,
    parameter  int TAG_W = 24,
    localparam int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic             valid  [SIZE];
    logic [TAG_W-1:0] tag    [SIZE];
    logic [31:0]      target [SIZE];

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rd_valid  = valid[rd_idx];
    assign rd_tag    = tag[rd_idx];
    assign rd_target = target[rd_idx];

    // Clear wins over write; the two are never active together in practice.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid[wr_idx]  <= 1'b1;
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor with a direct-mapped BTB, speculative global
// history with mispredict recovery, and hit/miss statistics. After reset an
// INIT walk clears both tables before predictions are enabled.
module gshare_bp
    import tcore_param::*;
#(
    parameter int PHT_SIZE = PHT_SIZE_DEF,
    parameter int BTB_SIZE = BTB_SIZE_DEF,
    parameter int GHR_LEN  = GHR_LEN_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pred_valid_i,
    input  logic [31:0]        pred_pc_i,
    input  logic               pred_is_branch_i,
    output logic               pred_taken_o,
    output logic [31:0]        pred_target_o,
    output logic [GHR_LEN-1:0] pred_ghr_o,
    output logic               ready_o,
    input  logic               upd_valid_i,
    input  logic [31:0]        upd_pc_i,
    input  logic [GHR_LEN-1:0] upd_ghr_i,
    input  logic               upd_taken_i,
    input  logic [31:0]        upd_target_i,
    input  logic               upd_mispredict_i,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
);

    localparam int PI_W   = $clog2(PHT_SIZE);
    localparam int BI_W   = $clog2(BTB_SIZE);
    localparam int TAG_W  = 31 - BI_W;
    localparam int WALK_N = (PHT_SIZE > BTB_SIZE) ? PHT_SIZE : BTB_SIZE;
    localparam int WALK_W = $clog2(WALK_N);

    localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [31:0]         STAT_MAX = '1;

    bp_state_e           state, state_nxt;
    logic                init_act, walk_last, lookup;
    logic [WALK_W-1:0]   walk;
    logic [GHR_LEN-1:0]  ghr;
    logic [CNT_BITS-1:0] pht [PHT_SIZE];
    bp_upd_t             upd;

    logic [PI_W-1:0]  pred_pidx, upd_pidx;
    logic [BI_W-1:0]  pred_bidx, upd_bidx;
    logic [TAG_W-1:0] pred_tag, upd_tag;
    logic             btb_valid;
    logic [TAG_W-1:0] btb_tag;
    logic [31:0]      btb_target;
    logic             unused;

    // Bundle the resolved branch into the shared update record.
    always_comb begin
        upd                    = '0;
        upd.pc                 = upd_pc_i;
        upd.ghr[GHR_LEN-1:0]   = upd_ghr_i;
        upd.taken              = upd_taken_i;
        upd.target             = upd_target_i;
        upd.mispredict         = upd_mispredict_i;
    end

    // Bit 0 of the PC and the history MSB never reach an index.
    assign unused = ^{pred_pc_i[0], upd.pc[0], upd.ghr[GHR_MAX-1:GHR_LEN-1]};

    assign pred_pidx = pred_pc_i[PI_W:1] ^ ghr[PI_W-1:0];
    assign pred_bidx = pred_pc_i[BI_W:1];
    assign pred_tag  = pred_pc_i[31:BI_W+1];
    assign upd_pidx  = upd.pc[PI_W:1] ^ upd.ghr[PI_W-1:0];
    assign upd_bidx  = upd.pc[BI_W:1];
    assign upd_tag   = upd.pc[31:BI_W+1];

    assign walk_last = (walk == WALK_W'(WALK_N - 1));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_INIT;
        else         state <= state_nxt;
    end

    // Next state: leave INIT after the last table entry; RUN is terminal.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && walk_last) state_nxt = ST_RUN;
    end

    // FSM outputs.
    always_comb begin
        ready_o  = (state == ST_RUN);
        init_act = (state == ST_INIT);
    end

    // Init walk pointer, one table entry per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    walk <= '0;
        else if (init_act && !walk_last) walk <= walk + 1'b1;
    end

    // Combinational lookup against pre-edge table contents.
    assign lookup        = ready_o & pred_valid_i & pred_is_branch_i;
    assign pred_taken_o  = lookup & pht[pred_pidx][CNT_BITS-1] & btb_valid
                         & (btb_tag == pred_tag);
    assign pred_target_o = pred_taken_o ? btb_target : '0;
    assign pred_ghr_o    = ghr;

    // PHT: weakly not-taken during the walk, saturating training when running.
    always_ff @(posedge clk_i) begin
        if (init_act) begin
            pht[walk[PI_W-1:0]] <= CNT_INIT;
        end else if (upd_valid_i) begin
            if (upd.taken && pht[upd_pidx] != CNT_MAX)
                pht[upd_pidx] <= pht[upd_pidx] + 1'b1;
            else if (!upd.taken && pht[upd_pidx] != '0)
                pht[upd_pidx] <= pht[upd_pidx] - 1'b1;
        end
    end

    // Global history: mispredict recovery overrides the speculative shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr <= '0;
        end else if (ready_o) begin
            if (upd_valid_i && upd.mispredict) ghr <= {upd.ghr[GHR_LEN-2:0], upd.taken};
            else if (lookup)                    ghr <= {ghr[GHR_LEN-2:0], pred_taken_o};
        end
    end

    // Saturating hit/miss statistics over resolved branches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (ready_o && upd_valid_i) begin
            if (upd.mispredict) begin
                if (miss_cnt_o != STAT_MAX) miss_cnt_o <= miss_cnt_o + 32'd1;
            end else begin
                if (hit_cnt_o != STAT_MAX) hit_cnt_o <= hit_cnt_o + 32'd1;
            end
        end
    end

    bp_btb #(
        .SIZE  (BTB_SIZE),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk_i),
        .rd_idx    (pred_bidx),
        .rd_valid  (btb_valid),
        .rd_tag    (btb_tag),
        .rd_target (btb_target),
        .wr_en     (ready_o & upd_valid_i & upd.taken),
        .wr_idx    (upd_bidx),
        .wr_tag    (upd_tag),
        .wr_target (upd.target),
        .clr_en    (init_act),
        .clr_idx   (walk[BI_W-1:0])
    );

endmodule

// File: tb/tb_gshare_bp.sv
// Bench for gshare_bp: directed vector table, reset/INIT sequences, recovery
// priority, a non-default parameter instance and a randomized run against a
// behavioural predictor model.
module tb_gshare_bp;

    localparam logic [31:0] PC  = 32'h8000_0010;
    localparam logic [31:0] TGT = 32'h8000_0100;
    localparam logic [31:0] Z   = 32'd0;
    localparam logic        Y   = 1'b1;
    localparam logic        N   = 1'b0;
    localparam logic [9:0]  G0  = 10'd0;
    localparam logic [9:0]  G1  = 10'd1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        pv, pb, p_taken, rdy, uv, ut, um;
    logic [31:0] ppc, p_tgt, upc, utgt, hit, miss;
    logic [9:0]  p_ghr, ughr;

    // swept-parameter instance
    logic        pv2, pb2, p_taken2, rdy2, uv2, ut2, um2;
    logic [31:0] ppc2, p_tgt2, upc2, utgt2, hit2, miss2;
    logic [7:0]  p_ghr2, ughr2;

    int total = 0;
    int bad   = 0;

    gshare_bp dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pred_valid_i(pv), .pred_pc_i(ppc), .pred_is_branch_i(pb),
        .pred_taken_o(p_taken), .pred_target_o(p_tgt), .pred_ghr_o(p_ghr), .ready_o(rdy),
        .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ughr), .upd_taken_i(ut),
        .upd_target_i(utgt), .upd_mispredict_i(um),
        .hit_cnt_o(hit), .miss_cnt_o(miss)
    );

    gshare_bp #(.PHT_SIZE(64), .BTB_SIZE(256), .GHR_LEN(8), .CNT_BITS(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .pred_valid_i(pv2), .pred_pc_i(ppc2), .pred_is_branch_i(pb2),
        .pred_taken_o(p_taken2), .pred_target_o(p_tgt2), .pred_ghr_o(p_ghr2), .ready_o(rdy2),
        .upd_valid_i(uv2), .upd_pc_i(upc2), .upd_ghr_i(ughr2), .upd_taken_i(ut2),
        .upd_target_i(utgt2), .upd_mispredict_i(um2),
        .hit_cnt_o(hit2), .miss_cnt_o(miss2)
    );

    typedef struct {
        logic        uv;
        logic [9:0]  ughr;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        pv;
        logic        pb;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic [9:0]  e_ghr;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pv = 0; pb = 0; ppc = Z; uv = 0; upc = Z; ughr = G0; ut = 0; utgt = Z; um = 0;
        pv2 = 0; pb2 = 0; ppc2 = Z; uv2 = 0; upc2 = Z; ughr2 = 8'd0; ut2 = 0; utgt2 = Z; um2 = 0;
    endtask

    // Assert reset, check the asynchronous effect, hold two edges, release.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        idle();
        pv = 1; pb = 1; ppc = PC;
        #1;
        chk({name, "_ready"}, {31'd0, rdy}, Z);
        chk({name, "_taken"}, {31'd0, p_taken}, Z);
        chk({name, "_target"}, p_tgt, Z);
        chk({name, "_ghr"}, {22'd0, p_ghr}, Z);
        chk({name, "_hit"}, hit, Z);
        chk({name, "_miss"}, miss, Z);
        chk({name, "_ready2"}, {31'd0, rdy2}, Z);
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Count edges until ready while hammering the inputs, which INIT must ignore.
    task automatic wait_ready(input string name);
        int  n;
        bit  seen, quiet;
        n = 0; seen = 0; quiet = 1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n++;
            if (rdy) begin
                seen = 1;
                break;
            end
            pv = 1; pb = 1; ppc = PC; uv = 1; um = 1; ut = 1; upc = PC; utgt = TGT;
            ughr = 10'($urandom);
            #1;
            if (p_taken !== 1'b0) quiet = 0;
        end
        idle();
        chk({name, "_ready_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_init_cycles"}, n, 32'd256);
        chk({name, "_init_quiet"}, {31'd0, quiet}, 32'd1);
        chk({name, "_ghr"}, {22'd0, p_ghr}, Z);
        chk({name, "_hit"}, hit, Z);
        chk({name, "_miss"}, miss, Z);
        chk({name, "_ready2"}, {31'd0, rdy2}, 32'd1);
    endtask

    task automatic upd1(input logic [9:0] g, input logic t, input logic m);
        uv = 1; upc = PC; ughr = g; ut = t; utgt = TGT; um = m;
        tick();
        idle();
    endtask

    task automatic look1(input string name, input logic e);
        pv = 1; pb = 1; ppc = PC;
        #1;
        chk(name, {31'd0, p_taken}, {31'd0, e});
        tick();
        idle();
    endtask

    task automatic upd2(input logic t, input logic m);
        uv2 = 1; upc2 = PC; ughr2 = 8'd0; ut2 = t; utgt2 = TGT; um2 = m;
        tick();
        idle();
    endtask

    task automatic look2(input string name, input logic e);
        pv2 = 1; pb2 = 1; ppc2 = PC;
        #1;
        chk({name, "_taken"}, {31'd0, p_taken2}, {31'd0, e});
        chk({name, "_target"}, p_tgt2, e ? TGT : Z);
        tick();
        idle();
    endtask

    // behavioural reference state for the default instance
    int          pht_m  [256];
    bit          bv_m   [128];
    int unsigned btag_m [128];
    int unsigned btgt_m [128];
    int unsigned ghr_m, hit_m, miss_m;

    function automatic logic [31:0] pick_pc();
        return 32'h8000_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 1);
    endfunction

    initial begin
        //         uv ughr ut utgt um  pv pb  taken tgt ghr    hit    miss
        tbl[0]  = '{Y, G0, Y, TGT, N,  N, N,  N, Z,   G0,  32'd1, 32'd0};
        tbl[1]  = '{Y, G0, Y, TGT, N,  N, N,  N, Z,   G0,  32'd2, 32'd0};
        tbl[2]  = '{N, G0, N, Z,   N,  Y, Y,  Y, TGT, G0,  32'd2, 32'd0};
        tbl[3]  = '{Y, G0, N, Z,   Y,  N, N,  N, Z,   G1,  32'd2, 32'd1};
        tbl[4]  = '{Y, G0, N, Z,   N,  N, N,  N, Z,   G0,  32'd3, 32'd1};
        tbl[5]  = '{Y, G0, N, Z,   N,  N, N,  N, Z,   G0,  32'd4, 32'd1};
        tbl[6]  = '{Y, G0, N, Z,   N,  N, N,  N, Z,   G0,  32'd5, 32'd1};
        tbl[7]  = '{Y, G0, N, Z,   N,  N, N,  N, Z,   G0,  32'd6, 32'd1};
        tbl[8]  = '{N, G0, N, Z,   N,  Y, Y,  N, Z,   G0,  32'd6, 32'd1};
        tbl[9]  = '{Y, G0, Y, TGT, N,  N, N,  N, Z,   G0,  32'd7, 32'd1};
        tbl[10] = '{N, G0, N, Z,   N,  Y, Y,  N, Z,   G0,  32'd7, 32'd1};
        tbl[11] = '{Y, G0, Y, TGT, N,  N, N,  N, Z,   G0,  32'd8, 32'd1};
        tbl[12] = '{N, G0, N, Z,   N,  Y, N,  N, Z,   G0,  32'd8, 32'd1};
        tbl[13] = '{Y, G0, N, Z,   N,  Y, Y,  Y, TGT, G0,  32'd9, 32'd1};
        tbl[14] = '{N, G0, N, Z,   N,  Y, Y,  N, Z,   G1,  32'd9, 32'd1};

        idle();
        #2;
        do_reset("por");
        wait_ready("por");

        // train/hit, saturation, same-cycle read/write, BTB-only gating
        for (int i = 0; i < 15; i++) begin
            uv = tbl[i].uv; upc = PC; ughr = tbl[i].ughr; ut = tbl[i].ut;
            utgt = tbl[i].utgt; um = tbl[i].um;
            pv = tbl[i].pv; pb = tbl[i].pb; ppc = PC;
            #1;
            chk($sformatf("vec%0d_taken", i), {31'd0, p_taken}, {31'd0, tbl[i].e_taken});
            chk($sformatf("vec%0d_target", i), p_tgt, tbl[i].e_tgt);
            chk($sformatf("vec%0d_ghr", i), {22'd0, p_ghr}, {22'd0, tbl[i].e_ghr});
            tick();
            idle();
            chk($sformatf("vec%0d_hit", i), hit, tbl[i].e_hit);
            chk($sformatf("vec%0d_miss", i), miss, tbl[i].e_miss);
        end

        // reset in RUN clears statistics at once; reset 100 cycles into INIT restarts the walk
        #2;
        do_reset("run_rst");
        for (int i = 0; i < 100; i++) tick();
        do_reset("init_rst");
        wait_ready("rewalk");

        // recovery beats a same-cycle speculative shift
        upd1(10'd0, 1'b1, 1'b0); upd1(10'd0, 1'b1, 1'b0);
        upd1(10'd1, 1'b1, 1'b0); upd1(10'd1, 1'b1, 1'b0);
        upd1(10'd3, 1'b1, 1'b0); upd1(10'd3, 1'b1, 1'b0);
        look1("spec0_taken", 1'b1);
        look1("spec1_taken", 1'b1);
        look1("spec2_taken", 1'b1);
        chk("spec_ghr", {22'd0, p_ghr}, 32'd7);
        pv = 1; pb = 1; ppc = PC;
        uv = 1; upc = PC; ughr = 10'd3; ut = 0; utgt = Z; um = 1;
        tick();
        idle();
        chk("recover_ghr", {22'd0, p_ghr}, 32'd6);
        chk("recover_miss", miss, 32'd1);
        chk("recover_hit", hit, 32'd6);

        // fresh tables for the swept instance and the random run
        do_reset("sweep_rst");
        wait_ready("sweep");

        look2("p2_cold", 1'b0);
        for (int i = 0; i < 4; i++) upd2(1'b1, 1'b0);
        look2("p2_four_taken", 1'b1);
        for (int i = 0; i < 4; i++) upd2(1'b1, 1'b0);
        upd2(1'b0, 1'b1);
        upd2(1'b0, 1'b0);
        upd2(1'b0, 1'b0);
        look2("p2_sat_then_down3", 1'b1);
        upd2(1'b0, 1'b1);
        look2("p2_weak_nt", 1'b0);
        chk("p2_hit", hit2, 32'd10);
        chk("p2_miss", miss2, 32'd2);

        // randomized run on the default instance against the model
        for (int i = 0; i < 256; i++) pht_m[i] = 1;
        for (int i = 0; i < 128; i++) begin
            bv_m[i] = 0; btag_m[i] = 0; btgt_m[i] = 0;
        end
        ghr_m = 0; hit_m = 0; miss_m = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int unsigned pi, bi, ui, a, u;
            bit          e_t;
            pv   = ($urandom_range(0, 3) != 0);
            pb   = ($urandom_range(0, 1) != 0);
            ppc  = pick_pc();
            uv   = ($urandom_range(0, 1) != 0);
            upc  = pick_pc();
            ughr = 10'($urandom_range(0, 3));
            ut   = ($urandom_range(0, 1) != 0);
            utgt = $urandom & 32'hFFFF_FFFE;
            um   = ($urandom_range(0, 3) == 0);
            #1;
            a   = ppc;
            pi  = ((a >> 1) ^ ghr_m) % 256;
            bi  = (a >> 1) % 128;
            e_t = pv && pb && (pht_m[pi] >= 2) && bv_m[bi] && (btag_m[bi] == (a >> 8));
            chk($sformatf("rnd%0d_taken", cyc), {31'd0, p_taken}, {31'd0, e_t});
            chk($sformatf("rnd%0d_target", cyc), p_tgt, e_t ? btgt_m[bi] : Z);
            chk($sformatf("rnd%0d_ghr", cyc), {22'd0, p_ghr}, ghr_m);
            if (uv) begin
                u  = upc;
                ui = ((u >> 1) ^ ughr) % 256;
                if (ut && pht_m[ui] < 3) pht_m[ui]++;
                if (!ut && pht_m[ui] > 0) pht_m[ui]--;
                if (ut) begin
                    bv_m[(u >> 1) % 128]   = 1;
                    btag_m[(u >> 1) % 128] = u >> 8;
                    btgt_m[(u >> 1) % 128] = utgt;
                end
                if (um) miss_m++;
                else    hit_m++;
            end
            if (uv && um)      ghr_m = ((ughr << 1) | ut) % 1024;
            else if (pv && pb) ghr_m = ((ghr_m << 1) | e_t) % 1024;
            tick();
        end
        idle();
        chk("rnd_hit", hit, hit_m);
        chk("rnd_miss", miss, miss_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
